// File: rtl/syn_fifo_flags.sv
// Single-clock FIFO with fill count, programmable almost-full/almost-empty flags,
// standard or first-word-fall-through read port, sticky error flags and synchronous flush.
module syn_fifo_flags #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = 14,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  en_wr,
    input  logic                  en_rd,
    input  logic [DATA_WIDTH-1:0] Din,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] Dout,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   head_bin,
    output logic [ADDR_WIDTH:0]   tail_bin
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_V = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_V    = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_V    = (ADDR_WIDTH+1)'(AE_THRESH);
    localparam logic [ADDR_WIDTH:0] ONE_V   = (ADDR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0] head_q, head_d;
    logic [ADDR_WIDTH:0] tail_q, tail_d;
    logic                ovf_q, ovf_d;
    logic                udf_q, udf_d;

    logic [ADDR_WIDTH:0] count_w;
    logic                empty_w;
    logic                full_w;
    logic                wr_ok;
    logic                rd_ok;

    // Pointers carry an extra wrap bit, so the modular difference is the fill level 0..DEPTH.
    always_comb begin
        count_w = head_q - tail_q;
        empty_w = (count_w == '0);
        full_w  = (count_w == DEPTH_V);
        wr_ok   = en_wr & ~full_w & ~flush;
        rd_ok   = en_rd & ~empty_w & ~flush;
    end

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (wr_ok) head_d = head_q + ONE_V;
            if (rd_ok) tail_d = tail_q + ONE_V;
        end
    end

    // Error flags: a new error in the same cycle as clr_err keeps the flag set.
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (clr_err) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (en_wr & full_w & ~flush)  ovf_d = 1'b1;
        if (en_rd & empty_w & ~flush) udf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[head_q[ADDR_WIDTH-1:0]] <= Din;
    end

    generate
        if (FWFT == 0) begin : g_std
            logic [DATA_WIDTH-1:0] dout_q, dout_d;

            always_comb begin
                dout_d = dout_q;
                if (rd_ok) dout_d = mem[tail_q[ADDR_WIDTH-1:0]];
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) dout_q <= '0;
                else      dout_q <= dout_d;
            end

            assign Dout = dout_q;
        end else begin : g_fwft
            // Head of queue is always presented; it is meaningful only while empty is low.
            assign Dout = mem[tail_q[ADDR_WIDTH-1:0]];
        end
    endgenerate

    assign count        = count_w;
    assign empty        = empty_w;
    assign full         = full_w;
    assign almost_empty = (count_w <= AE_V);
    assign almost_full  = (count_w >= AF_V);
    assign overflow     = ovf_q;
    assign underflow    = udf_q;
    assign head_bin     = head_q;
    assign tail_bin     = tail_q;

endmodule

// File: tb/tb_syn_fifo_flags.sv
// Directed bench for syn_fifo_flags: one standard-read instance and one FWFT instance
// sharing clock and reset.
module tb_syn_fifo_flags;

    logic clk;
    logic rst;

    logic       s_flush, s_en_wr, s_en_rd, s_clr;
    logic [7:0] s_din;
    logic [7:0] s_dout;
    logic       s_empty, s_full, s_ae, s_af, s_ovf, s_udf;
    logic [4:0] s_count, s_head, s_tail;

    logic       f_flush, f_en_wr, f_en_rd, f_clr;
    logic [7:0] f_din;
    logic [7:0] f_dout;
    logic       f_empty, f_full, f_ae, f_af, f_ovf, f_udf;
    logic [4:0] f_count, f_head, f_tail;

    int n_pass;
    int n_total;
    logic [7:0] exp_q[$];
    logic [7:0] last_rd;

    syn_fifo_flags #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .FWFT(0), .AF_THRESH(14), .AE_THRESH(2)) u_std (
        .clk(clk), .rst(rst), .flush(s_flush), .en_wr(s_en_wr), .en_rd(s_en_rd),
        .Din(s_din), .clr_err(s_clr), .Dout(s_dout), .empty(s_empty), .full(s_full),
        .almost_empty(s_ae), .almost_full(s_af), .count(s_count), .overflow(s_ovf),
        .underflow(s_udf), .head_bin(s_head), .tail_bin(s_tail)
    );

    syn_fifo_flags #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .FWFT(1), .AF_THRESH(14), .AE_THRESH(2)) u_fwft (
        .clk(clk), .rst(rst), .flush(f_flush), .en_wr(f_en_wr), .en_rd(f_en_rd),
        .Din(f_din), .clr_err(f_clr), .Dout(f_dout), .empty(f_empty), .full(f_full),
        .almost_empty(f_ae), .almost_full(f_af), .count(f_count), .overflow(f_ovf),
        .underflow(f_udf), .head_bin(f_head), .tail_bin(f_tail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        s_flush = 0; s_en_wr = 0; s_en_rd = 0; s_clr = 0; s_din = '0;
        f_flush = 0; f_en_wr = 0; f_en_rd = 0; f_clr = 0; f_din = '0;
        tick();
        tick();
        n_total++; if ({s_empty, s_full, s_ae, s_af} !== 4'b1010) $display("FAIL reset_flags got=%b exp=1010", {s_empty, s_full, s_ae, s_af}); else n_pass++;
        n_total++; if (s_count !== 5'd0) $display("FAIL reset_count got=%0d exp=0", s_count); else n_pass++;
        n_total++; if (s_dout !== 8'h00) $display("FAIL reset_dout got=%h exp=00", s_dout); else n_pass++;
        n_total++; if ({s_ovf, s_udf} !== 2'b00) $display("FAIL reset_err got=%b exp=00", {s_ovf, s_udf}); else n_pass++;
        n_total++; if ({s_head, s_tail} !== 10'd0) $display("FAIL reset_ptr got=%h/%h exp=0/0", s_head, s_tail); else n_pass++;
        n_total++; if ({f_empty, f_count} !== {1'b1, 5'd0}) $display("FAIL reset_fwft got=%b/%0d exp=1/0", f_empty, f_count); else n_pass++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            s_en_wr = 1'b1;
            s_din = 8'(i);
            tick();
            n_total++; if (s_count !== 5'(i + 1)) $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, s_count, i + 1); else n_pass++;
            n_total++; if (s_af !== ((i + 1) >= 14)) $display("FAIL fill_af[%0d] got=%b exp=%b", i, s_af, ((i + 1) >= 14)); else n_pass++;
            n_total++; if (s_full !== ((i + 1) == 16)) $display("FAIL fill_full[%0d] got=%b exp=%b", i, s_full, ((i + 1) == 16)); else n_pass++;
        end
        s_en_wr = 1'b0;
        n_total++; if (s_head !== 5'h10) $display("FAIL fill_head got=%h exp=10", s_head); else n_pass++;
        n_total++; if (s_empty !== 1'b0) $display("FAIL fill_empty got=%b exp=0", s_empty); else n_pass++;
    endtask

    task automatic test_overflow();
        s_en_wr = 1'b1;
        s_din = 8'hAA;
        tick();
        s_en_wr = 1'b0;
        n_total++; if (s_ovf !== 1'b1) $display("FAIL ovf_set got=%b exp=1", s_ovf); else n_pass++;
        n_total++; if (s_count !== 5'd16) $display("FAIL ovf_count got=%0d exp=16", s_count); else n_pass++;
        n_total++; if (s_head !== 5'h10) $display("FAIL ovf_head got=%h exp=10", s_head); else n_pass++;
        s_clr = 1'b1;
        tick();
        s_clr = 1'b0;
        n_total++; if (s_ovf !== 1'b0) $display("FAIL ovf_clr got=%b exp=0", s_ovf); else n_pass++;
        // New error in the same cycle as clr_err must win.
        s_clr = 1'b1;
        s_en_wr = 1'b1;
        tick();
        s_clr = 1'b0;
        s_en_wr = 1'b0;
        n_total++; if (s_ovf !== 1'b1) $display("FAIL ovf_set_wins got=%b exp=1", s_ovf); else n_pass++;
        s_clr = 1'b1;
        tick();
        s_clr = 1'b0;
        n_total++; if (s_ovf !== 1'b0) $display("FAIL ovf_clr2 got=%b exp=0", s_ovf); else n_pass++;
    endtask

    task automatic test_read_std();
        for (int i = 0; i < 16; i++) begin
            s_en_rd = 1'b1;
            tick();
            n_total++; if (s_dout !== 8'(i)) $display("FAIL rd_data[%0d] got=%h exp=%h", i, s_dout, 8'(i)); else n_pass++;
            n_total++; if (s_ae !== ((15 - i) <= 2)) $display("FAIL rd_ae[%0d] got=%b exp=%b", i, s_ae, ((15 - i) <= 2)); else n_pass++;
        end
        s_en_rd = 1'b0;
        n_total++; if (s_empty !== 1'b1) $display("FAIL rd_empty got=%b exp=1", s_empty); else n_pass++;
        n_total++; if (s_tail !== 5'h10) $display("FAIL rd_tail got=%h exp=10", s_tail); else n_pass++;
        s_en_rd = 1'b1;
        tick();
        s_en_rd = 1'b0;
        n_total++; if (s_udf !== 1'b1) $display("FAIL udf_set got=%b exp=1", s_udf); else n_pass++;
        n_total++; if (s_tail !== 5'h10) $display("FAIL udf_tail got=%h exp=10", s_tail); else n_pass++;
        n_total++; if (s_dout !== 8'h0F) $display("FAIL udf_dout_hold got=%h exp=0f", s_dout); else n_pass++;
        s_clr = 1'b1;
        tick();
        s_clr = 1'b0;
        n_total++; if (s_udf !== 1'b0) $display("FAIL udf_clr got=%b exp=0", s_udf); else n_pass++;
        last_rd = 8'h0F;
    endtask

    task automatic test_back_to_back();
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            s_en_wr = 1'b1;
            s_din = 8'h30 + 8'(i);
            exp_q.push_back(s_din);
            tick();
        end
        s_en_wr = 1'b0;
        n_total++; if (s_count !== 5'd8) $display("FAIL b2b_prefill got=%0d exp=8", s_count); else n_pass++;
        for (int k = 0; k < 20; k++) begin
            s_en_wr = 1'b1;
            s_en_rd = 1'b1;
            s_din = 8'h40 + 8'(k);
            exp_q.push_back(s_din);
            last_rd = exp_q.pop_front();
            tick();
            n_total++; if (s_count !== 5'd8) $display("FAIL b2b_count[%0d] got=%0d exp=8", k, s_count); else n_pass++;
            n_total++; if (s_dout !== last_rd) $display("FAIL b2b_data[%0d] got=%h exp=%h", k, s_dout, last_rd); else n_pass++;
        end
        s_en_wr = 1'b0;
        s_en_rd = 1'b0;
        n_total++; if (s_head !== 5'h0C) $display("FAIL b2b_head got=%h exp=0c", s_head); else n_pass++;
        n_total++; if (s_tail !== 5'h04) $display("FAIL b2b_tail got=%h exp=04", s_tail); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            s_en_rd = 1'b1;
            last_rd = exp_q.pop_front();
            tick();
            n_total++; if (s_dout !== last_rd) $display("FAIL b2b_drain[%0d] got=%h exp=%h", i, s_dout, last_rd); else n_pass++;
        end
        s_en_rd = 1'b0;
        n_total++; if (s_empty !== 1'b1) $display("FAIL b2b_empty got=%b exp=1", s_empty); else n_pass++;
        // Write and read together while empty: write only, read rejected.
        s_en_wr = 1'b1;
        s_en_rd = 1'b1;
        s_din = 8'h99;
        tick();
        s_en_wr = 1'b0;
        s_en_rd = 1'b0;
        n_total++; if (s_count !== 5'd1) $display("FAIL empty_wr_rd_count got=%0d exp=1", s_count); else n_pass++;
        n_total++; if (s_udf !== 1'b1) $display("FAIL empty_wr_rd_udf got=%b exp=1", s_udf); else n_pass++;
        n_total++; if (s_dout !== last_rd) $display("FAIL empty_wr_rd_dout got=%h exp=%h", s_dout, last_rd); else n_pass++;
        s_clr = 1'b1;
        s_en_rd = 1'b1;
        tick();
        s_clr = 1'b0;
        s_en_rd = 1'b0;
        last_rd = 8'h99;
        n_total++; if (s_dout !== 8'h99) $display("FAIL empty_wr_rd_pop got=%h exp=99", s_dout); else n_pass++;
        n_total++; if ({s_empty, s_udf} !== 2'b10) $display("FAIL empty_wr_rd_end got=%b exp=10", {s_empty, s_udf}); else n_pass++;
    endtask

    task automatic test_fwft();
        f_en_wr = 1'b1;
        f_din = 8'h5A;
        tick();
        f_en_wr = 1'b0;
        n_total++; if (f_empty !== 1'b0) $display("FAIL fwft_not_empty got=%b exp=0", f_empty); else n_pass++;
        n_total++; if (f_dout !== 8'h5A) $display("FAIL fwft_dout got=%h exp=5a", f_dout); else n_pass++;
        f_en_rd = 1'b1;
        tick();
        f_en_rd = 1'b0;
        n_total++; if (f_empty !== 1'b1) $display("FAIL fwft_empty got=%b exp=1", f_empty); else n_pass++;
        f_en_wr = 1'b1;
        f_din = 8'h11;
        tick();
        f_din = 8'h22;
        tick();
        f_en_wr = 1'b0;
        n_total++; if (f_dout !== 8'h11) $display("FAIL fwft_head1 got=%h exp=11", f_dout); else n_pass++;
        f_en_rd = 1'b1;
        tick();
        f_en_rd = 1'b0;
        n_total++; if (f_dout !== 8'h22) $display("FAIL fwft_head2 got=%h exp=22", f_dout); else n_pass++;
        n_total++; if (f_count !== 5'd1) $display("FAIL fwft_count got=%0d exp=1", f_count); else n_pass++;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            s_en_wr = 1'b1;
            s_din = 8'h60 + 8'(i);
            tick();
        end
        s_en_wr = 1'b0;
        n_total++; if (s_count !== 5'd5) $display("FAIL flush_pre got=%0d exp=5", s_count); else n_pass++;
        s_flush = 1'b1;
        s_en_wr = 1'b1;
        s_din = 8'hEE;
        tick();
        s_flush = 1'b0;
        s_en_wr = 1'b0;
        n_total++; if ({s_count, s_empty} !== {5'd0, 1'b1}) $display("FAIL flush_count got=%0d/%b exp=0/1", s_count, s_empty); else n_pass++;
        n_total++; if ({s_head, s_tail} !== 10'd0) $display("FAIL flush_ptr got=%h/%h exp=0/0", s_head, s_tail); else n_pass++;
        n_total++; if (s_dout !== last_rd) $display("FAIL flush_dout got=%h exp=%h", s_dout, last_rd); else n_pass++;
        s_flush = 1'b1;
        s_en_rd = 1'b1;
        tick();
        s_flush = 1'b0;
        s_en_rd = 1'b0;
        n_total++; if ({s_udf, s_ovf} !== 2'b00) $display("FAIL flush_no_err got=%b exp=00", {s_udf, s_ovf}); else n_pass++;
        s_en_wr = 1'b1;
        s_din = 8'h77;
        tick();
        s_en_wr = 1'b0;
        s_en_rd = 1'b1;
        tick();
        s_en_rd = 1'b0;
        n_total++; if (s_dout !== 8'h77) $display("FAIL flush_then_rw got=%h exp=77", s_dout); else n_pass++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            s_en_wr = 1'b1;
            f_en_wr = 1'b1;
            s_din = 8'h80 + 8'(i);
            f_din = 8'h90 + 8'(i);
            tick();
        end
        n_total++; if (s_count !== 5'd3) $display("FAIL mid_pre got=%0d exp=3", s_count); else n_pass++;
        #2;
        rst = 1'b0;
        #1;
        n_total++; if ({s_count, s_head, s_tail} !== 15'd0) $display("FAIL mid_ptr got=%0d/%h/%h exp=0/0/0", s_count, s_head, s_tail); else n_pass++;
        n_total++; if ({s_empty, s_full, s_ae, s_af} !== 4'b1010) $display("FAIL mid_flags got=%b exp=1010", {s_empty, s_full, s_ae, s_af}); else n_pass++;
        n_total++; if (s_dout !== 8'h00) $display("FAIL mid_dout got=%h exp=00", s_dout); else n_pass++;
        n_total++; if ({f_count, f_empty} !== {5'd0, 1'b1}) $display("FAIL mid_fwft got=%0d/%b exp=0/1", f_count, f_empty); else n_pass++;
        s_en_wr = 1'b0;
        f_en_wr = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        n_total++; if (s_count !== 5'd0) $display("FAIL mid_after got=%0d exp=0", s_count); else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        last_rd = '0;
        test_reset();
        test_fill();
        test_overflow();
        test_read_std();
        test_back_to_back();
        test_fwft();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
